mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 18 +
 rtl/mem_arbiter_arb_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  localparam int unsigned NUM_PORTS          = 2;
  localparam int unsigned DEFAULT_ADDR_WIDTH = 16;
  localparam int unsigned DEFAULT_DATA_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational winner selection for the arbiter.
// MEM_ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; otherwise port 0 has fixed priority.
module arb_pick
  import mem_arb_pkg::*;
(
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic                 i_last,
  output logic [NUM_PORTS-1:0] o_grant
);

`ifndef MEM_ARB_ROUND_ROBIN_EN
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  always_comb begin
    o_grant = '0;
    case (i_req)
      2'b01: o_grant = 2'b01;
      2'b10: o_grant = 2'b10;
      2'b11: begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
        // The port that was not granted last takes the tie.
        o_grant = i_last ? 2'b01 : 2'b10;
`else
        o_grant = 2'b01;
`endif
      end
      default: o_grant = '0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter onto a single registered memory bus; each access is IDLE -> ACCESS -> RESP.
// MEM_ARB_ROUND_ROBIN_EN enables the last-grant pointer and round-robin ties.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic                  m0_req,
  input  logic                  m0_we_n,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_done,
  output logic [DATA_WIDTH-1:0] m0_rdata,

  input  logic                  m1_req,
  input  logic                  m1_we_n,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_done,
  output logic [DATA_WIDTH-1:0] m1_rdata,

  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we_n,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  state_e                r_state;
  logic                  r_win;
  logic                  r_win_rd;
  logic [NUM_PORTS-1:0]  r_gnt;
  logic [NUM_PORTS-1:0]  r_done;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_we_n;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic [NUM_PORTS-1:0]  w_req;
  logic [NUM_PORTS-1:0]  w_grant;
  logic                  w_last;
  logic                  w_win;
  logic                  w_sel_we_n;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic                  w_resp_rd;

  assign w_req       = {m1_req, m0_req};
  assign w_win       = w_grant[1];
  assign w_sel_we_n  = w_win ? m1_we_n  : m0_we_n;
  assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
  assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;

  arb_pick u_arb_pick (
    .i_req   (w_req),
    .i_last  (w_last),
    .o_grant (w_grant)
  );

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic r_last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last <= 1'b1;
    end else if (r_state == IDLE && |w_req) begin
      r_last <= w_win;
    end
  end

  assign w_last = r_last;
`else
  assign w_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_win       <= 1'b0;
      r_win_rd    <= 1'b1;
      r_gnt       <= '0;
      r_done      <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we_n  <= 1'b1;
      r_rdata0    <= '0;
      r_rdata1    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_req) begin
            r_state     <= ACCESS;
            r_win       <= w_win;
            r_win_rd    <= w_sel_we_n;
            r_gnt       <= w_grant;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_we_n  <= w_sel_we_n;
          end
        end
        ACCESS: begin
          r_state    <= RESP;
          r_gnt      <= '0;
          r_done     <= port_onehot(r_win);
          r_mem_we_n <= 1'b1;
        end
        RESP: begin
          r_state <= IDLE;
          r_done  <= '0;
          if (r_win_rd) begin
            if (r_win) r_rdata1 <= mem_rdata;
            else       r_rdata0 <= mem_rdata;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read data arrives during RESP, so the winner sees it live and the register keeps it afterwards.
  assign w_resp_rd = (r_state == RESP) && r_win_rd;
  assign m0_rdata  = (w_resp_rd && !r_win) ? mem_rdata : r_rdata0;
  assign m1_rdata  = (w_resp_rd &&  r_win) ? mem_rdata : r_rdata1;

  assign m0_gnt    = r_gnt[0];
  assign m1_gnt    = r_gnt[1];
  assign m0_done   = r_done[0];
  assign m1_done   = r_done[1];
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_we_n  = r_mem_we_n;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (memory contents, per-port read data, arbitration rule).
module tb_mem_arbiter;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          p_req   [2];
  logic          p_we_n  [2];
  logic [AW-1:0] p_addr  [2];
  logic [DW-1:0] p_wdata [2];

  logic          m0_gnt, m0_done, m1_gnt, m1_done, mem_we_n;
  logic [DW-1:0] m0_rdata, m1_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;

  bit   [DW-1:0] ram     [0:65535];
  bit   [DW-1:0] exp_mem [0:65535];
  logic [DW-1:0] exp_rd  [2];
  bit            exp_last;

  int checks = 0;
  int failures = 0;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0_req    (p_req[0]),
    .m0_we_n   (p_we_n[0]),
    .m0_addr   (p_addr[0]),
    .m0_wdata  (p_wdata[0]),
    .m0_gnt    (m0_gnt),
    .m0_done   (m0_done),
    .m0_rdata  (m0_rdata),
    .m1_req    (p_req[1]),
    .m1_we_n   (p_we_n[1]),
    .m1_addr   (p_addr[1]),
    .m1_wdata  (p_wdata[1]),
    .m1_gnt    (m1_gnt),
    .m1_done   (m1_done),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we_n  (mem_we_n),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous memory: one-cycle read latency after mem_addr.
  always @(posedge clk) begin
    if (mem_we_n === 1'b0) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic gnt_of(input int p);
    return (p == 1) ? m1_gnt : m0_gnt;
  endfunction

  function automatic logic done_of(input int p);
    return (p == 1) ? m1_done : m0_done;
  endfunction

  function automatic logic [DW-1:0] rdata_of(input int p);
    return (p == 1) ? m1_rdata : m0_rdata;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    chk("gnt_exclusive", 32'(m0_gnt & m1_gnt), 32'd0);
    chk("done_exclusive", 32'(m0_done & m1_done), 32'd0);
    chk("we_only_in_access", 32'(!mem_we_n && !(m0_gnt || m1_gnt)), 32'd0);
  endtask

  task automatic set_op(input int p, input logic we_n, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    p_req[p]   = 1'b1;
    p_we_n[p]  = we_n;
    p_addr[p]  = a;
    p_wdata[p] = d;
  endtask

  task automatic new_op(input int p);
    set_op(p, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)), DW'($urandom));
  endtask

  // One full access from an IDLE cycle. mode: 0 winner maybe re-requests, 1 always, 2 drops.
  task automatic txn(input int mode, input bit force_other, output int obs_w);
    int            w;
    int            o;
    bit            rd;
    logic [DW-1:0] rv;
    if (p_req[0] && p_req[1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w = exp_last ? 0 : 1;
`else
      w = 0;
`endif
    end else begin
      w = p_req[0] ? 0 : 1;
    end
    o = 1 - w;
    exp_last = (w == 1);
    rd = p_we_n[w];
    rv = exp_mem[p_addr[w]];

    tick();
    obs_w = m1_gnt ? 1 : 0;
    chk("access_gnt_winner", 32'(gnt_of(w)), 32'd1);
    chk("access_gnt_loser", 32'(gnt_of(o)), 32'd0);
    chk("access_done", 32'({m1_done, m0_done}), 32'd0);
    chk("access_mem_addr", 32'(mem_addr), 32'(p_addr[w]));
    chk("access_mem_wdata", 32'(mem_wdata), 32'(p_wdata[w]));
    chk("access_mem_we_n", 32'(mem_we_n), 32'(rd));
    if (!p_req[o] && (force_other || $urandom_range(0, 3) == 0)) new_op(o);

    tick();
    chk("resp_done_winner", 32'(done_of(w)), 32'd1);
    chk("resp_done_loser", 32'(done_of(o)), 32'd0);
    chk("resp_gnt", 32'({m1_gnt, m0_gnt}), 32'd0);
    chk("resp_mem_we_n", 32'(mem_we_n), 32'd1);
    if (rd) exp_rd[w] = rv;
    else    exp_mem[p_addr[w]] = p_wdata[w];
    chk("resp_rdata_winner", 32'(rdata_of(w)), 32'(exp_rd[w]));
    chk("resp_rdata_loser", 32'(rdata_of(o)), 32'(exp_rd[o]));

    tick();
    chk("idle_gnt_done", 32'({m1_gnt, m0_gnt, m1_done, m0_done}), 32'd0);
    chk("idle_mem_we_n", 32'(mem_we_n), 32'd1);
    chk("idle_mem_addr_hold", 32'(mem_addr), 32'(p_addr[w]));
    chk("idle_rdata0", 32'(m0_rdata), 32'(exp_rd[0]));
    chk("idle_rdata1", 32'(m1_rdata), 32'(exp_rd[1]));
    if (mode == 1 || (mode == 0 && $urandom_range(0, 1) == 1)) new_op(w);
    else p_req[w] = 1'b0;
  endtask

  task automatic drain();
    int w;
    for (int i = 0; i < 4 && (p_req[0] || p_req[1]); i++) txn(2, 1'b0, w);
    chk("drained", 32'({p_req[1], p_req[0]}), 32'd0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_we_n"}, 32'(mem_we_n), 32'd1);
    chk({tag, "_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_gnt_done"}, 32'({m1_gnt, m0_gnt, m1_done, m0_done}), 32'd0);
    chk({tag, "_rdata"}, 32'({m1_rdata, m0_rdata}), 32'd0);
  endtask

  initial begin
    int w;
    int seq [4];
    int exp_seq [4];
    for (int p = 0; p < 2; p++) begin
      p_req[p] = 1'b0; p_we_n[p] = 1'b1; p_addr[p] = '0; p_wdata[p] = '0; exp_rd[p] = '0;
    end
    exp_last = 1'b1;

    #1 reset_n = 1'b0;
    #2 chk_reset_outputs("por");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // m0 read of 0x0010 holding 0x1234 (loaded with an m0 write first).
    set_op(0, 1'b0, 16'h0010, 16'h1234);
    txn(2, 1'b0, w);
    set_op(0, 1'b1, 16'h0010, 16'h0000);
    txn(2, 1'b0, w);
    chk("m0_read_0010", 32'(m0_rdata), 32'h1234);

    // m1 write then read back.
    set_op(1, 1'b0, 16'h0020, 16'hBEEF);
    txn(2, 1'b0, w);
    set_op(1, 1'b1, 16'h0020, 16'h0000);
    txn(2, 1'b0, w);
    chk("m1_read_0020", 32'(m1_rdata), 32'hBEEF);

    // Simultaneous held requests, four accesses.
    new_op(0);
    new_op(1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) txn(1, 1'b0, seq[i]);
    for (int i = 0; i < 4; i++) chk($sformatf("tie_winner_%0d", i), 32'(seq[i]), 32'(exp_seq[i]));
    drain();

    // m1 arrives during m0's ACCESS: served only after the next IDLE.
    set_op(0, 1'b1, 16'h0020, 16'h0000);
    txn(2, 1'b1, w);
    chk("late_req_not_granted_in_idle", 32'(m1_gnt), 32'd0);
    txn(2, 1'b0, w);
    chk("late_req_winner", 32'(w), 32'd1);
    drain();

    // Reset during an m0 write in ACCESS.
    set_op(0, 1'b0, 16'h0005, 16'hA5A5);
    tick();
    chk("rst_pre_we_n", 32'(mem_we_n), 32'd0);
    chk("rst_pre_gnt", 32'(m0_gnt), 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    p_req[0] = 1'b0;
    tick();
    chk("rst_no_done", 32'(m0_done), 32'd0);
    reset_n = 1'b1;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    exp_last = 1'b1;
    tick();
    chk("rst_idle_gnt_done", 32'({m1_gnt, m0_gnt, m1_done, m0_done}), 32'd0);
    chk("rst_idle_we_n", 32'(mem_we_n), 32'd1);
    set_op(0, 1'b1, 16'h0005, 16'h0000);
    txn(2, 1'b0, w);
    chk("rst_write_aborted", 32'(m0_rdata), 32'(exp_mem[16'h0005]));

    // Randomized traffic.
    for (int i = 0; i < 150; i++) begin
      if (!p_req[0] && $urandom_range(0, 2) == 0) new_op(0);
      if (!p_req[1] && $urandom_range(0, 2) == 0) new_op(1);
      if (p_req[0] || p_req[1]) begin
        txn(0, 1'b0, w);
      end else begin
        tick();
        chk("rand_idle_gnt_done", 32'({m1_gnt, m0_gnt, m1_done, m0_done}), 32'd0);
        chk("rand_idle_we_n", 32'(mem_we_n), 32'd1);
      end
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
